// File: rtl/trace_pkg.sv
// Shared types and constants for the retire-stream trace buffer controller.
package trace_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_POST    = 2'd2,
        ST_DONE    = 2'd3
    } trace_state_e;

    localparam logic [4:0] OFF_CTRL     = 5'h00;
    localparam logic [4:0] OFF_STATUS   = 5'h04;
    localparam logic [4:0] OFF_TRIG_PC  = 5'h08;
    localparam logic [4:0] OFF_POST_CNT = 5'h0C;
    localparam logic [4:0] OFF_RD_PC    = 5'h10;
    localparam logic [4:0] OFF_RD_INST  = 5'h14;
    localparam logic [4:0] OFF_RD_META  = 5'h18;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_WRAP    = 1;
    localparam int CTRL_TRIG_EN = 2;

    // The stored pc is the 32 bits that RD_PC can expose to software.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [1:0]  prv;
        logic        trap;
    } trace_rec_t;

endpackage

// File: rtl/trace_ram.sv
// Record storage: one synchronous write port, one asynchronous read port, no reset.
module trace_ram
    import trace_pkg::*;
#(
    parameter int DEPTH = 64,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  trace_rec_t    wdata,
    input  logic [AW-1:0] raddr,
    output trace_rec_t    rdata
);

    trace_rec_t mem [DEPTH];

    // Store the retired record at the write pointer.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/trace_buf_ctrl.sv
// Instruction-trace capture controller: circular record buffer with PC trigger,
// post-trigger count and a small software register interface for readout.
module trace_buf_ctrl
    import trace_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 64
) (
    input  logic            clk,
    input  logic            srst,
    input  logic            tr_valid,
    input  logic [XLEN-1:0] tr_pc,
    input  logic [31:0]     tr_inst,
    input  logic [1:0]      tr_prv,
    input  logic            tr_trap,
    input  logic            tr_halted,
    input  logic            reg_req,
    input  logic            reg_wr,
    input  logic [4:0]      reg_addr,
    input  logic [31:0]     reg_wdata,
    output logic [31:0]     reg_rdata,
    output logic            reg_ack,
    output logic            irq_done
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    trace_state_e    state, state_next;
    logic [2:0]      ctrl;
    logic [XLEN-1:0] trig_pc;
    logic [15:0]     post_cnt;
    logic [15:0]     post_rem, post_rem_next;
    logic [AW-1:0]   wr_ptr, wr_ptr_next;
    logic [AW-1:0]   rd_ptr, rd_ptr_next;
    logic [CW-1:0]   count, count_next;
    logic            wrapped, wrapped_next;

    logic            rd_access, wr_access, ctrl_wr;
    logic            en_rise, en_fall;
    logic            capture, trig_hit, readable, pop, done_entry;
    logic [CW-1:0]   count_cap;
    logic [31:0]     status, rdata_mux;
    trace_rec_t      wr_rec, rd_rec;

    assign rd_access = reg_req & ~reg_wr;
    assign wr_access = reg_req & reg_wr;
    assign ctrl_wr   = wr_access && (reg_addr == OFF_CTRL);
    assign en_rise   = ctrl_wr & reg_wdata[CTRL_EN] & ~ctrl[CTRL_EN];
    assign en_fall   = ctrl_wr & ~reg_wdata[CTRL_EN] & ctrl[CTRL_EN];

    // A retire racing an enable or disable write is dropped.
    assign capture   = ((state == ST_CAPTURE) || (state == ST_POST)) &&
                       tr_valid && !tr_halted && !en_rise && !en_fall;
    assign count_cap = (count == FULL) ? count : count + CW'(1);
    assign trig_hit  = (state == ST_CAPTURE) && ctrl[CTRL_TRIG_EN] && (tr_pc == trig_pc);
    assign readable  = ((state == ST_IDLE) || (state == ST_DONE)) && (count != '0);
    assign pop       = rd_access && (reg_addr == OFF_RD_META) && readable;

    assign wr_rec.pc   = 32'(tr_pc);
    assign wr_rec.inst = tr_inst;
    assign wr_rec.prv  = tr_prv;
    assign wr_rec.trap = tr_trap;

    trace_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (capture),
        .waddr (wr_ptr),
        .wdata (wr_rec),
        .raddr (rd_ptr),
        .rdata (rd_rec)
    );

    // State register.
    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: control writes first, then trigger, then post countdown or full stop.
    always_comb begin
        state_next = state;
        if (en_rise) begin
            state_next = ST_CAPTURE;
        end else if (en_fall) begin
            state_next = ST_IDLE;
        end else if (capture) begin
            case (state)
                ST_CAPTURE: begin
                    if (trig_hit) begin
                        state_next = (post_cnt == '0) ? ST_DONE : ST_POST;
                    end else if (!ctrl[CTRL_WRAP] && (count_cap == FULL)) begin
                        state_next = ST_DONE;
                    end
                end
                ST_POST: begin
                    if (post_rem == 16'd1) begin
                        state_next = ST_DONE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign done_entry = (state_next == ST_DONE) && (state != ST_DONE);

    // Pointer, count and post-countdown updates; rd_ptr snaps to the oldest record on stop.
    always_comb begin
        wr_ptr_next   = wr_ptr;
        rd_ptr_next   = rd_ptr;
        count_next    = count;
        wrapped_next  = wrapped;
        post_rem_next = post_rem;
        if (en_rise) begin
            wr_ptr_next   = '0;
            rd_ptr_next   = '0;
            count_next    = '0;
            wrapped_next  = 1'b0;
            post_rem_next = '0;
        end else begin
            if (capture) begin
                wr_ptr_next = wr_ptr + AW'(1);
                if (count == FULL) begin
                    wrapped_next = 1'b1;
                end else begin
                    count_next = count + CW'(1);
                end
                if (trig_hit) begin
                    post_rem_next = post_cnt;
                end else if (state == ST_POST) begin
                    post_rem_next = post_rem - 16'd1;
                end
            end
            if (pop) begin
                rd_ptr_next = rd_ptr + AW'(1);
                count_next  = count - CW'(1);
            end
            if (en_fall || done_entry) begin
                rd_ptr_next = wr_ptr_next - count_next[AW-1:0];
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            wrapped  <= 1'b0;
            post_rem <= '0;
        end else begin
            wr_ptr   <= wr_ptr_next;
            rd_ptr   <= rd_ptr_next;
            count    <= count_next;
            wrapped  <= wrapped_next;
            post_rem <= post_rem_next;
        end
    end

    // Software-writable configuration registers.
    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            ctrl     <= '0;
            trig_pc  <= '0;
            post_cnt <= '0;
        end else if (wr_access) begin
            case (reg_addr)
                OFF_CTRL:     ctrl     <= reg_wdata[2:0];
                OFF_TRIG_PC:  trig_pc  <= XLEN'(reg_wdata);
                OFF_POST_CNT: post_cnt <= reg_wdata[15:0];
                default: ;
            endcase
        end
    end

    // Read data select; buffer windows read 0 unless readout is permitted.
    always_comb begin
        status          = '0;
        status[1:0]     = state;
        status[3]       = wrapped;
        status[16 +: CW] = count;
        rdata_mux = '0;
        case (reg_addr)
            OFF_CTRL:     rdata_mux = {29'b0, ctrl};
            OFF_STATUS:   rdata_mux = status;
            OFF_TRIG_PC:  rdata_mux = 32'(trig_pc);
            OFF_POST_CNT: rdata_mux = {16'b0, post_cnt};
            OFF_RD_PC:    rdata_mux = readable ? rd_rec.pc : '0;
            OFF_RD_INST:  rdata_mux = readable ? rd_rec.inst : '0;
            OFF_RD_META:  rdata_mux = readable ? {29'b0, rd_rec.trap, rd_rec.prv} : '0;
            default:      rdata_mux = '0;
        endcase
    end

    // Registered register response and done interrupt pulse.
    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            reg_ack   <= 1'b0;
            reg_rdata <= '0;
            irq_done  <= 1'b0;
        end else begin
            reg_ack   <= reg_req;
            reg_rdata <= rd_access ? rdata_mux : '0;
            irq_done  <= done_entry;
        end
    end

endmodule

// File: tb/tb_trace_buf_ctrl.sv
// Self-checking bench for trace_buf_ctrl: a record scoreboard filled as retires are
// driven and drained through the register readout interface.
module tb_trace_buf_ctrl;
    import trace_pkg::*;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [2:0]  meta;
    } exp_t;

    logic        clk;
    logic        srst;
    logic        tr_valid;
    logic [31:0] tr_pc;
    logic [31:0] tr_inst;
    logic [1:0]  tr_prv;
    logic        tr_trap;
    logic        tr_halted;
    logic        reg_req;
    logic        reg_wr;
    logic [4:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic [31:0] reg_rdata;
    logic        reg_ack;
    logic        irq_done;

    int checks = 0;
    int errors = 0;
    int irq_count = 0;
    exp_t sb[$];
    logic [31:0] rq[$];

    trace_buf_ctrl #(
        .XLEN  (32),
        .DEPTH (64)
    ) dut (
        .clk       (clk),
        .srst      (srst),
        .tr_valid  (tr_valid),
        .tr_pc     (tr_pc),
        .tr_inst   (tr_inst),
        .tr_prv    (tr_prv),
        .tr_trap   (tr_trap),
        .tr_halted (tr_halted),
        .reg_req   (reg_req),
        .reg_wr    (reg_wr),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_rdata (reg_rdata),
        .reg_ack   (reg_ack),
        .irq_done  (irq_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count done pulses, sampled mid-cycle.
    always @(negedge clk) begin
        if (irq_done === 1'b1) irq_count++;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic exp_t make_rec(input logic [31:0] pc);
        exp_t e;
        e.pc   = pc;
        e.inst = pc ^ 32'hA5A5_0000;
        e.meta = {pc[4], pc[3:2]};
        return e;
    endfunction

    task automatic reg_access(input logic wr, input logic [4:0] addr, input logic [31:0] wdata,
                              output logic [31:0] rdata, output logic ack);
        reg_req   = 1'b1;
        reg_wr    = wr;
        reg_addr  = addr;
        reg_wdata = wdata;
        @(negedge clk);
        reg_req   = 1'b0;
        reg_wr    = 1'b0;
        rdata     = reg_rdata;
        ack       = reg_ack;
    endtask

    task automatic retire(input logic [31:0] pc, input logic halted);
        tr_valid  = 1'b1;
        tr_pc     = pc;
        tr_inst   = pc ^ 32'hA5A5_0000;
        tr_prv    = pc[3:2];
        tr_trap   = pc[4];
        tr_halted = halted;
        @(negedge clk);
        tr_valid  = 1'b0;
        tr_halted = 1'b0;
    endtask

    task automatic read_record(output exp_t got);
        logic [31:0] rd;
        logic ack;
        reg_access(1'b0, OFF_RD_PC, 32'h0, rd, ack);
        got.pc = rd;
        reg_access(1'b0, OFF_RD_INST, 32'h0, rd, ack);
        got.inst = rd;
        reg_access(1'b0, OFF_RD_META, 32'h0, rd, ack);
        got.meta = rd[2:0];
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        logic ack;
        checks++;
        if (reg_rdata !== 32'h0 || reg_ack !== 1'b0 || irq_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: rdata=%h ack=%b irq=%b, need 0/0/0", reg_rdata, reg_ack, irq_done);
        end
        @(negedge clk);
        srst = 1'b0;
        reg_access(1'b0, OFF_STATUS, 32'h0, rd, ack);
        checks++;
        if (rd !== 32'h0 || ack !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_status: got %h ack=%b, need 00000000 ack=1", rd, ack);
        end
        reg_access(1'b0, OFF_CTRL, 32'h0, rd, ack);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: got %h, need 00000000", rd);
        end
    endtask

    task automatic test_basic_capture();
        logic [31:0] rd;
        logic ack;
        exp_t got, e;
        int irq0;
        sb.delete();
        reg_access(1'b1, OFF_CTRL, 32'h1, rd, ack);
        irq0 = irq_count;
        for (int k = 0; k < 70; k++) begin
            retire(32'h1000 + 32'(k) * 32'd4, 1'b0);
            if (k < 64) sb.push_back(make_rec(32'h1000 + 32'(k) * 32'd4));
            if (k == 62 || k == 63) begin
                reg_access(1'b0, OFF_STATUS, 32'h0, rd, ack);
                checks++;
                if (rd !== ((k == 62) ? 32'h003F_0001 : 32'h0040_0003)) begin
                    errors++;
                    $display("[TB] FAIL basic_status_k%0d: got %h", k, rd);
                end
            end
        end
        checks++;
        if (irq_count - irq0 != 1) begin
            errors++;
            $display("[TB] FAIL basic_irq: got %0d pulses, need 1", irq_count - irq0);
        end
        reg_access(1'b0, OFF_STATUS, 32'h0, rd, ack);
        checks++;
        if (rd !== 32'h0040_0003) begin
            errors++;
            $display("[TB] FAIL basic_status_full: got %h, need 00400003", rd);
        end
        while (sb.size() > 0) begin
            read_record(got);
            e = sb.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("[TB] FAIL basic_readout: got pc=%h inst=%h meta=%h, need pc=%h inst=%h meta=%h",
                         got.pc, got.inst, got.meta, e.pc, e.inst, e.meta);
            end
        end
        reg_access(1'b0, OFF_STATUS, 32'h0, rd, ack);
        checks++;
        if (rd !== 32'h0000_0003) begin
            errors++;
            $display("[TB] FAIL basic_status_drained: got %h, need 00000003", rd);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] rd;
        logic ack;
        exp_t got, e;
        int irq0;
        sb.delete();
        reg_access(1'b1, OFF_CTRL, 32'h0, rd, ack);
        reg_access(1'b1, OFF_CTRL, 32'h3, rd, ack);
        irq0 = irq_count;
        for (int k = 0; k < 100; k++) begin
            retire(32'h1000 + 32'(k) * 32'd4, 1'b0);
            sb.push_back(make_rec(32'h1000 + 32'(k) * 32'd4));
            if (sb.size() > 64) void'(sb.pop_front());
        end
        reg_access(1'b1, OFF_CTRL, 32'h2, rd, ack);
        checks++;
        if (irq_count != irq0) begin
            errors++;
            $display("[TB] FAIL wrap_irq: got %0d pulses, need 0", irq_count - irq0);
        end
        reg_access(1'b0, OFF_STATUS, 32'h0, rd, ack);
        checks++;
        if (rd !== 32'h0040_0008) begin
            errors++;
            $display("[TB] FAIL wrap_status: got %h, need 00400008", rd);
        end
        while (sb.size() > 0) begin
            read_record(got);
            e = sb.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("[TB] FAIL wrap_readout: got pc=%h inst=%h meta=%h, need pc=%h inst=%h meta=%h",
                         got.pc, got.inst, got.meta, e.pc, e.inst, e.meta);
            end
        end
    endtask

    task automatic test_trigger(input logic [31:0] base, input logic [31:0] tpc,
                                input logic [15:0] post, input int stored);
        logic [31:0] rd;
        logic ack;
        exp_t got, e;
        int irq0;
        sb.delete();
        reg_access(1'b1, OFF_CTRL, 32'h0, rd, ack);
        reg_access(1'b1, OFF_TRIG_PC, tpc, rd, ack);
        reg_access(1'b1, OFF_POST_CNT, {16'h0, post}, rd, ack);
        reg_access(1'b0, OFF_TRIG_PC, 32'h0, rd, ack);
        checks++;
        if (rd !== tpc) begin
            errors++;
            $display("[TB] FAIL trig_pc_readback: got %h, need %h", rd, tpc);
        end
        reg_access(1'b1, OFF_CTRL, 32'h5, rd, ack);
        irq0 = irq_count;
        for (int k = 0; k < 40; k++) begin
            retire(base + 32'(k) * 32'd4, 1'b0);
            if (k < stored) sb.push_back(make_rec(base + 32'(k) * 32'd4));
        end
        checks++;
        if (irq_count - irq0 != 1) begin
            errors++;
            $display("[TB] FAIL trig_irq_post%0d: got %0d pulses, need 1", post, irq_count - irq0);
        end
        reg_access(1'b0, OFF_STATUS, 32'h0, rd, ack);
        checks++;
        if (rd !== {16'(stored), 16'h0003}) begin
            errors++;
            $display("[TB] FAIL trig_status_post%0d: got %h, need %h", post, rd, {16'(stored), 16'h0003});
        end
        while (sb.size() > 0) begin
            read_record(got);
            e = sb.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("[TB] FAIL trig_readout_post%0d: got pc=%h meta=%h, need pc=%h meta=%h",
                         post, got.pc, got.meta, e.pc, e.meta);
            end
        end
        reg_access(1'b1, OFF_CTRL, 32'h0, rd, ack);
    endtask

    task automatic test_halt_priority();
        logic [31:0] rd;
        logic ack;
        exp_t got, e;
        sb.delete();
        reg_access(1'b1, OFF_CTRL, 32'h1, rd, ack);
        for (int k = 0; k < 3; k++) begin
            retire(32'h4000 + 32'(k) * 32'd4, 1'b0);
            sb.push_back(make_rec(32'h4000 + 32'(k) * 32'd4));
        end
        for (int k = 0; k < 10; k++) retire(32'h4100 + 32'(k) * 32'd4, 1'b1);
        reg_access(1'b0, OFF_STATUS, 32'h0, rd, ack);
        checks++;
        if (rd !== 32'h0003_0001) begin
            errors++;
            $display("[TB] FAIL halt_status: got %h, need 00030001", rd);
        end
        tr_valid = 1'b1; tr_pc = 32'h4200; tr_inst = 32'h0; tr_prv = 2'd0; tr_trap = 1'b0;
        reg_access(1'b1, OFF_CTRL, 32'h0, rd, ack);
        tr_valid = 1'b0;
        reg_access(1'b0, OFF_STATUS, 32'h0, rd, ack);
        checks++;
        if (rd !== 32'h0003_0000) begin
            errors++;
            $display("[TB] FAIL disable_race_status: got %h, need 00030000", rd);
        end
        while (sb.size() > 0) begin
            read_record(got);
            e = sb.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("[TB] FAIL halt_readout: got pc=%h, need pc=%h", got.pc, e.pc);
            end
        end
        tr_valid = 1'b1; tr_pc = 32'h4300;
        reg_access(1'b1, OFF_CTRL, 32'h1, rd, ack);
        tr_valid = 1'b0;
        reg_access(1'b0, OFF_STATUS, 32'h0, rd, ack);
        checks++;
        if (rd !== 32'h0000_0001) begin
            errors++;
            $display("[TB] FAIL enable_race_status: got %h, need 00000001", rd);
        end
    endtask

    task automatic test_readout_edges();
        logic [31:0] rd;
        logic ack;
        exp_t got, e;
        sb.delete();
        reg_access(1'b0, OFF_RD_META, 32'h0, rd, ack);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("[TB] FAIL edge_meta_empty_capture: got %h, need 0", rd);
        end
        retire(32'h4410, 1'b0);
        sb.push_back(make_rec(32'h4410));
        retire(32'h441C, 1'b0);
        sb.push_back(make_rec(32'h441C));
        reg_access(1'b0, OFF_RD_PC, 32'h0, rd, ack);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("[TB] FAIL edge_rdpc_capture: got %h, need 0", rd);
        end
        reg_access(1'b0, OFF_RD_META, 32'h0, rd, ack);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("[TB] FAIL edge_meta_capture: got %h, need 0", rd);
        end
        reg_access(1'b0, OFF_STATUS, 32'h0, rd, ack);
        checks++;
        if (rd !== 32'h0002_0001) begin
            errors++;
            $display("[TB] FAIL edge_status_capture: got %h, need 00020001", rd);
        end
        reg_access(1'b1, OFF_CTRL, 32'h0, rd, ack);
        while (sb.size() > 0) begin
            read_record(got);
            e = sb.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("[TB] FAIL edge_readout: got pc=%h meta=%h, need pc=%h meta=%h",
                         got.pc, got.meta, e.pc, e.meta);
            end
        end
        reg_access(1'b0, OFF_RD_META, 32'h0, rd, ack);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("[TB] FAIL edge_meta_empty: got %h, need 0", rd);
        end
        reg_access(1'b0, OFF_STATUS, 32'h0, rd, ack);
        checks++;
        if (rd !== 32'h0000_0000) begin
            errors++;
            $display("[TB] FAIL edge_status_empty: got %h, need 00000000", rd);
        end
        reg_access(1'b0, 5'h1C, 32'h0, rd, ack);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("[TB] FAIL edge_unmapped: got %h, need 0", rd);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        logic ack;
        exp_t e;
        rq.delete();
        reg_access(1'b1, OFF_CTRL, 32'h1, rd, ack);
        for (int k = 0; k < 4; k++) retire(32'h6000 + 32'(k) * 32'd4, 1'b0);
        reg_access(1'b1, OFF_CTRL, 32'h0, rd, ack);
        for (int i = 0; i <= 8; i++) begin
            if (i > 0) begin
                checks++;
                if (reg_ack !== 1'b1 || reg_rdata !== rq[0]) begin
                    errors++;
                    $display("[TB] FAIL b2b_read%0d: got ack=%b data=%h, need ack=1 data=%h",
                             i - 1, reg_ack, reg_rdata, rq[0]);
                end
                void'(rq.pop_front());
            end
            if (i < 8) begin
                e = make_rec(32'h6000 + 32'(i / 2) * 32'd4);
                reg_req  = 1'b1;
                reg_wr   = 1'b0;
                reg_addr = (i % 2 == 0) ? OFF_RD_PC : OFF_RD_META;
                rq.push_back((i % 2 == 0) ? e.pc : {29'b0, e.meta});
            end else begin
                reg_req = 1'b0;
            end
            @(negedge clk);
        end
        reg_access(1'b0, OFF_STATUS, 32'h0, rd, ack);
        checks++;
        if (rd !== 32'h0000_0000) begin
            errors++;
            $display("[TB] FAIL b2b_status: got %h, need 00000000", rd);
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] rd;
        logic ack;
        reg_access(1'b1, OFF_TRIG_PC, 32'h7000, rd, ack);
        reg_access(1'b1, OFF_POST_CNT, 32'd10, rd, ack);
        reg_access(1'b1, OFF_CTRL, 32'h5, rd, ack);
        retire(32'h7000, 1'b0);
        retire(32'h7004, 1'b0);
        reg_access(1'b0, OFF_STATUS, 32'h0, rd, ack);
        checks++;
        if (rd !== 32'h0002_0002) begin
            errors++;
            $display("[TB] FAIL reset_pre_post_status: got %h, need 00020002", rd);
        end
        reg_access(1'b0, OFF_CTRL, 32'h0, rd, ack);
        checks++;
        if (ack !== 1'b1 || rd !== 32'h5) begin
            errors++;
            $display("[TB] FAIL reset_pre_ctrl: got ack=%b data=%h, need ack=1 data=5", ack, rd);
        end
        #2;
        srst = 1'b1;
        #1;
        checks++;
        if (reg_ack !== 1'b0 || reg_rdata !== 32'h0 || irq_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_async_outputs: ack=%b rdata=%h irq=%b, need 0/0/0",
                     reg_ack, reg_rdata, irq_done);
        end
        @(negedge clk);
        srst = 1'b0;
        reg_access(1'b0, OFF_STATUS, 32'h0, rd, ack);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_async_status: got %h, need 00000000", rd);
        end
        reg_access(1'b0, OFF_POST_CNT, 32'h0, rd, ack);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_async_post_cnt: got %h, need 00000000", rd);
        end
    endtask

    initial begin
        srst = 1'b1;
        tr_valid = 1'b0; tr_pc = '0; tr_inst = '0; tr_prv = '0; tr_trap = 1'b0; tr_halted = 1'b0;
        reg_req = 1'b0; reg_wr = 1'b0; reg_addr = '0; reg_wdata = '0;
        @(negedge clk);
        test_reset();
        test_basic_capture();
        test_wrap();
        test_trigger(32'h2000, 32'h2040, 16'd5, 22);
        test_trigger(32'h3000, 32'h3010, 16'd0, 5);
        test_halt_priority();
        test_readout_edges();
        test_back_to_back();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/trace_buf_ctrl.md
Name: trace_buf_ctrl

Overview:
- Hardware instruction-trace capture controller for the CPU retire stream (valid/pc/inst/prv/trap).
- Stores retired-instruction records in a circular buffer, with optional PC trigger and post-trigger count.
- Buffer is read out by software through a small register interface.
- Sits beside the core retire stage; the silicon counterpart of the simulation tracer, usable on FPGA/debug builds.

Parameters:
- XLEN, 32, width of pc and register data path.
- DEPTH, 64, number of trace records; power of two, 2..1024.
- CW, $clog2(DEPTH)+1, width of record count (derived, not overridable).

Ports:
- clk  in  1  core clock.
- srst  in  1  asynchronous active-high reset.
- tr_valid  in  1  instruction retired this cycle.
- tr_pc  in  XLEN  retired pc.
- tr_inst  in  32  retired instruction (compressed in [15:0]).
- tr_prv  in  2  privilege level.
- tr_trap  in  1  trap taken on this retire.
- tr_halted  in  1  core in debug halt; suppresses capture.
- reg_req  in  1  register access request.
- reg_wr  in  1  1 = write, 0 = read.
- reg_addr  in  5  byte offset, word aligned.
- reg_wdata  in  32  write data.
- reg_rdata  out  32  read data, valid with reg_ack.
- reg_ack  out  1  access complete.
- irq_done  out  1  one-cycle pulse on entry to DONE.

Behaviour:
- Reset (srst asserted, asynchronous): state = IDLE; all pointers, count, wrapped, CTRL, TRIG_PC and POST_CNT = 0; reg_rdata = 0; reg_ack = 0; irq_done = 0.
- Register map:
  - 0x00 CTRL: [0] en, [1] wrap, [2] trig_en; read/write.
  - 0x04 STATUS: [2:0] state, [3] wrapped, [CW+15:16] count; read-only.
  - 0x08 TRIG_PC: read/write.
  - 0x0C POST_CNT: [15:0]; read/write.
  - 0x10 RD_PC, 0x14 RD_INST: read-only.
  - 0x18 RD_META: {29'b0, trap, prv}; read pops the record.
  - Unmapped offsets read 0; writes to them are ignored.
- Register access: reg_ack is asserted exactly 1 cycle after reg_req; reg_rdata is registered and 0 when not acked. Back-to-back requests are allowed every cycle.
- States: IDLE=0, CAPTURE=1, POST=2, DONE=3.
- CTRL.en 0->1 write (any state):
  - wr_ptr, rd_ptr, count, wrapped and post_rem are cleared next cycle.
  - Next state = CAPTURE.
- CTRL.en 1->0 write (any state):
  - Next state = IDLE.
  - rd_ptr = (wr_ptr - count) mod DEPTH, i.e. the oldest record.
  - irq_done does not pulse.
- Capture: in CAPTURE or POST, when tr_valid & ~tr_halted:
  - Record {pc, inst, prv, trap} is written at wr_ptr, then wr_ptr++ mod DEPTH.
  - If count == DEPTH, wrapped = 1; otherwise count++.
- Non-wrap mode (wrap = 0): the write that makes count == DEPTH moves the state to DONE in the same update.
- Wrap mode (wrap = 1): capture continues, overwriting the oldest record.
- Trigger: in CAPTURE with trig_en = 1, a captured record with tr_pc == TRIG_PC moves the state to POST with post_rem = POST_CNT.
  - If POST_CNT == 0, the state goes straight to DONE; the trigger record is the last record stored.
  - A trigger has priority over the non-wrap full stop, so a simultaneous full and trigger goes to POST, or to DONE if POST_CNT == 0.
  - In POST, the buffer always wraps regardless of CTRL.wrap.
- POST: each captured record decrements post_rem; the capture that brings post_rem to 0 moves the state to DONE.
- Entry to DONE:
  - rd_ptr = oldest record.
  - irq_done pulses high for exactly 1 cycle.
  - No further capture.
- Readout: allowed only in IDLE or DONE with count > 0.
  - RD_PC and RD_INST return the record at rd_ptr without popping.
  - A read of RD_META returns meta, then rd_ptr++ mod DEPTH and count--.
  - With count == 0, or in CAPTURE/POST, reads of RD_* return 0 and do not pop.
- Simultaneous events:
  - A disable write and a tr_valid in the same cycle: the disable wins and the record is dropped.
  - An enable write and a tr_valid in the same cycle: the record is dropped; capture starts the next cycle.
- Writes to TRIG_PC and POST_CNT during POST have no effect on the post_rem already loaded.

Decomposition:
- Package trace_pkg holds:
  - trace_state_e enum;
  - register offset localparams;
  - trace_rec_t packed struct {pc, inst, prv, trap};
  - CTRL bit index constants.
- Sub-module trace_ram:
  - DEPTH x $bits(trace_rec_t) register array;
  - one synchronous write port and one asynchronous read port;
  - no reset on the array.

Test Plan:
- Basic capture: en=1, wrap=0, DEPTH=64, 70 retires with pc=0x1000+4k -> DONE after the 64th; irq_done 1 pulse; count=64; wrapped=0; readout yields pc 0x1000..0x10FC in order.
- Wrap mode: en=1, wrap=1, 100 retires, then write en=0 -> IDLE; count=64; wrapped=1; first RD_PC=0x1000+4*36; no irq_done.
- Trigger: trig_en=1, TRIG_PC=0x2040, POST_CNT=5, sequential pcs from 0x2000 -> DONE after pc 0x2054; last record read = 0x2054; trigger record present.
- POST_CNT=0 -> DONE on the trigger record itself.
- Halt and priority: tr_halted=1 during 10 retires -> count unchanged; en=0 write in the same cycle as tr_valid -> record dropped; count unchanged.
- Readout edges: RD_META read with count=0 -> 0 and no pointer change; RD_* read during CAPTURE -> 0.
- Reset: srst asserted mid-POST -> all outputs 0 and state IDLE immediately, without waiting for a clock edge.
